// File: rtl/ap_ctrl_mc_pkg.sv
// Shared types and elaboration helpers for the multi-channel ap control sequencer.
// The watchdog build is selected with AP_CTRL_WDOG_EN.
package ap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        WAIT = 2'd2,
        RUN  = 2'd3
    } ch_state_e;

    // One counter serves both the launch delays and the RUN watchdog.
    function automatic int cnt_w(input int start_delay, input int wdog_cycles);
        int m;
        m = (start_delay > wdog_cycles) ? start_delay : wdog_cycles;
        return $clog2(m + 1);
    endfunction

    function automatic bit params_ok(input int n_ch, input int rst_delay,
                                     input int start_delay, input int wdog_cycles);
        return (n_ch >= 1) && (n_ch <= 32) && (rst_delay >= 1) &&
               (start_delay > rst_delay) && (wdog_cycles >= 1);
    endfunction

endpackage

// File: rtl/ap_ctrl_mc_if.sv
// Host handshake and per-channel control bundle for ap_ctrl_mc.
// ch_timeout exists only when AP_CTRL_WDOG_EN is defined.
interface ap_ctrl_mc_if #(
    parameter int N_CH = 4
);
    logic            ap_start;
    logic [N_CH-1:0] ch_en;
    logic [N_CH-1:0] ch_done;
    logic [N_CH-1:0] ch_rst_n;
    logic [N_CH-1:0] ch_start_pulse;
    logic [N_CH-1:0] ch_busy;
    logic            ap_idle;
    logic            ap_ready;
    logic            ap_done;
`ifdef AP_CTRL_WDOG_EN
    logic [N_CH-1:0] ch_timeout;

    modport master (
        output ap_start, ch_en, ch_done,
        input  ch_rst_n, ch_start_pulse, ch_busy, ap_idle, ap_ready, ap_done, ch_timeout
    );
    modport slave (
        input  ap_start, ch_en, ch_done,
        output ch_rst_n, ch_start_pulse, ch_busy, ap_idle, ap_ready, ap_done, ch_timeout
    );
`else
    modport master (
        output ap_start, ch_en, ch_done,
        input  ch_rst_n, ch_start_pulse, ch_busy, ap_idle, ap_ready, ap_done
    );
    modport slave (
        input  ap_start, ch_en, ch_done,
        output ch_rst_n, ch_start_pulse, ch_busy, ap_idle, ap_ready, ap_done
    );
`endif
endinterface

// File: rtl/ap_ctrl_mc_ch_seq.sv
// Per-channel launch sequencer: auto-reset window, delayed start pulse, done tracking.
// Optional RUN watchdog under AP_CTRL_WDOG_EN.
//
// state | meaning
// IDLE  | channel parked, ch_rst_n high, waiting for a launch with its enable bit set
// RST   | ch_rst_n low, down-counter runs C_RST_DELAY cycles
// WAIT  | ch_rst_n high, down-counter runs until the start pulse is due
// RUN   | start pulse on entry cycle, then waiting for ch_done (or watchdog expiry)
module ap_ch_seq
    import ap_ctrl_pkg::*;
#(
    parameter int C_RST_DELAY   = 20,
    parameter int C_START_DELAY = 40,
`ifdef AP_CTRL_WDOG_EN
    parameter int C_WDOG_CYCLES = 1048576,
`endif
    parameter int CNT_W         = 21
) (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic launch,
    input  logic en,
    input  logic ch_done,
    output logic ch_rst_n,
    output logic ch_start_pulse,
    output logic ch_busy,
    output logic done_evt
`ifdef AP_CTRL_WDOG_EN
    ,
    output logic ch_timeout
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(C_RST_DELAY - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(C_START_DELAY - C_RST_DELAY - 1);
`ifdef AP_CTRL_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(C_WDOG_CYCLES - 1);
    logic timeout_set;
    logic timeout_q;
`endif

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_n_q;
    logic             pulse_q, pulse_d;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rst_n_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= (state_d != RST);
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        done_evt = 1'b0;
`ifdef AP_CTRL_WDOG_EN
        timeout_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (launch && en) begin
                    state_d = RST;
                    cnt_d   = RST_LOAD;
                end
            end
            RST: begin
                if (cnt_q == '0) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                    pulse_d = 1'b1;
`ifdef AP_CTRL_WDOG_EN
                    cnt_d   = WDOG_LOAD;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RUN: begin
                // The pulse cycle itself never qualifies for done or watchdog counting.
                if (!pulse_q && ch_done) begin
                    state_d  = IDLE;
                    done_evt = 1'b1;
                end
`ifdef AP_CTRL_WDOG_EN
                else if (!pulse_q && (cnt_q == '0)) begin
                    state_d     = IDLE;
                    done_evt    = 1'b1;
                    timeout_set = 1'b1;
                end else if (!pulse_q) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AP_CTRL_WDOG_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            timeout_q <= 1'b0;
        end else if (launch) begin
            timeout_q <= 1'b0;
        end else if (timeout_set) begin
            timeout_q <= 1'b1;
        end
    end

    assign ch_timeout = timeout_q;
`endif

    assign ch_rst_n       = rst_n_q;
    assign ch_start_pulse = pulse_q;
    assign ch_busy        = (state_q != IDLE);

endmodule

// File: rtl/ap_ctrl_mc.sv
// Multi-channel ap control sequencer: host start edge detect, channel fan-out, status aggregation.
// Per-channel RUN watchdog and ch_timeout are built only with AP_CTRL_WDOG_EN.
module ap_ctrl_mc
    import ap_ctrl_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int C_RST_DELAY   = 20,
    parameter int C_START_DELAY = 40,
    parameter int C_WDOG_CYCLES = 1048576,
    parameter int CNT_W         = cnt_w(C_START_DELAY, C_WDOG_CYCLES)
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    ap_ctrl_mc_if.slave  ctrl
);

    if (!params_ok(N_CH, C_RST_DELAY, C_START_DELAY, C_WDOG_CYCLES)) begin : g_param_err
        $error("ap_ctrl_mc: illegal parameter combination");
    end

    logic            start_q;
    logic [N_CH-1:0] en_q;
    logic [N_CH-1:0] done_q;
    logic [N_CH-1:0] done_nxt;
    logic [N_CH-1:0] done_evt;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] rst_n_w;
    logic [N_CH-1:0] pulse_w;
    logic            all_idle;
    logic            launch;
    logic            fire;
    logic            ap_ready_q;
    logic            ap_done_q;
`ifdef AP_CTRL_WDOG_EN
    logic [N_CH-1:0] timeout_w;
`endif

    assign all_idle = ~(|busy);
    assign launch   = ctrl.ap_start & ~start_q & all_idle & (|ctrl.ch_en);
    assign done_nxt = done_q | done_evt;
    // Completion is judged on the edge that carries the last done, so ap_done is one cycle later.
    assign fire     = (|done_evt) && (done_nxt == en_q);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            start_q    <= 1'b0;
            en_q       <= '0;
            done_q     <= '0;
            ap_ready_q <= 1'b0;
            ap_done_q  <= 1'b0;
        end else begin
            start_q    <= ctrl.ap_start;
            ap_ready_q <= launch;
            ap_done_q  <= fire;
            if (launch) begin
                en_q   <= ctrl.ch_en;
                done_q <= '0;
            end else if (fire) begin
                done_q <= '0;
            end else begin
                done_q <= done_nxt;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ap_ch_seq #(
            .C_RST_DELAY   (C_RST_DELAY),
            .C_START_DELAY (C_START_DELAY),
`ifdef AP_CTRL_WDOG_EN
            .C_WDOG_CYCLES (C_WDOG_CYCLES),
`endif
            .CNT_W         (CNT_W)
        ) u_ch (
            .ap_clk         (ap_clk),
            .ap_rst         (ap_rst),
            .launch         (launch),
            .en             (ctrl.ch_en[i]),
            .ch_done        (ctrl.ch_done[i]),
            .ch_rst_n       (rst_n_w[i]),
            .ch_start_pulse (pulse_w[i]),
            .ch_busy        (busy[i]),
            .done_evt       (done_evt[i])
`ifdef AP_CTRL_WDOG_EN
            ,
            .ch_timeout     (timeout_w[i])
`endif
        );
    end

    assign ctrl.ch_rst_n       = rst_n_w;
    assign ctrl.ch_start_pulse = pulse_w;
    assign ctrl.ch_busy        = busy;
    assign ctrl.ap_idle        = all_idle;
    assign ctrl.ap_ready       = ap_ready_q;
    assign ctrl.ap_done        = ap_done_q;
`ifdef AP_CTRL_WDOG_EN
    assign ctrl.ch_timeout     = timeout_w;
`endif

endmodule
